// File: rtl/cp0_exc_ctrl.sv
// Picks one exception, interrupt or ERET per instruction boundary and writes CP0.
// The CP0 write lands one cycle after the event is sampled, and the flush/redirect lands one cycle after that.
module cp0_exc_ctrl #(
   parameter int                WIDTH      = 32,
   parameter logic [WIDTH-1:0]  EXC_VECTOR = 32'hBFC00380
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             commit_valid,
   input  logic [WIDTH-1:0] commit_pc,
   input  logic             commit_in_ds,
   input  logic             exc_valid,
   input  logic [4:0]       exc_code,
   input  logic [WIDTH-1:0] exc_badvaddr,
   input  logic             eret_valid,
   input  logic [WIDTH-1:0] status_in,
   input  logic [WIDTH-1:0] cause_in,
   input  logic [WIDTH-1:0] epc_in,
   input  logic [5:0]       hw_int,
   output logic [WIDTH-1:0] cp0_we,
   output logic [WIDTH-1:0] cp0_epc,
   output logic [WIDTH-1:0] cp0_badvaddr,
   output logic             cp0_exl,
   output logic             cp0_bd,
   output logic [4:0]       cp0_exc_code,
   output logic             stall,
   output logic             flush,
   output logic             redirect_valid,
   output logic [WIDTH-1:0] redirect_pc
);

   typedef enum logic [1:0] {IDLE, WRITE, REDIRECT} state_t;

   state_t           state;
   logic             kind_eret;
   logic             int_pending;
   logic             sel_int;
   logic             sel_exc;
   logic             sel_eret;
   logic             event_sel;
   logic             badv_code;
   logic [WIDTH-1:0] epc_val;
   logic [WIDTH-1:0] next_we;
   logic             unused_bits;

   assign unused_bits = ^{status_in[WIDTH-1:16], status_in[7:2], cause_in[WIDTH-1:10], cause_in[7:0]};

   assign int_pending = status_in[0] & ~status_in[1] & (|(status_in[15:8] & {hw_int, cause_in[9:8]}));
   assign sel_int     = commit_valid & int_pending;
   assign sel_exc     = commit_valid & ~int_pending & exc_valid;
   assign sel_eret    = commit_valid & ~int_pending & ~exc_valid & eret_valid;
   assign event_sel   = (state == IDLE) & (sel_int | sel_exc | sel_eret);
   assign badv_code   = sel_exc & (exc_code >= 5'd1) & (exc_code <= 5'd5);
   assign epc_val     = commit_in_ds ? commit_pc - WIDTH'(4) : commit_pc;

   assign stall       = (state != IDLE) | event_sel;
   // EPC is untouched by an ERET write, so the live value is safe to use here.
   assign redirect_pc = redirect_valid ? (kind_eret ? epc_in : EXC_VECTOR) : '0;

   always_comb begin
      next_we     = '0;
      next_we[12] = 1'b1;
      if (!sel_eret) begin
         next_we[13] = 1'b1;
         next_we[14] = 1'b1;
         next_we[8]  = badv_code;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         kind_eret      <= 1'b0;
         cp0_we         <= '0;
         cp0_epc        <= '0;
         cp0_badvaddr   <= '0;
         cp0_exl        <= 1'b0;
         cp0_bd         <= 1'b0;
         cp0_exc_code   <= '0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               flush          <= 1'b0;
               redirect_valid <= 1'b0;
               if (event_sel) begin
                  state        <= WRITE;
                  kind_eret    <= sel_eret;
                  cp0_we       <= next_we;
                  cp0_epc      <= sel_eret ? '0 : epc_val;
                  cp0_badvaddr <= badv_code ? exc_badvaddr : '0;
                  cp0_exl      <= ~sel_eret;
                  cp0_bd       <= sel_eret ? 1'b0 : commit_in_ds;
                  cp0_exc_code <= sel_exc ? exc_code : 5'd0;
               end
            end
            WRITE: begin
               state          <= REDIRECT;
               cp0_we         <= '0;
               cp0_epc        <= '0;
               cp0_badvaddr   <= '0;
               cp0_exl        <= 1'b0;
               cp0_bd         <= 1'b0;
               cp0_exc_code   <= '0;
               flush          <= 1'b1;
               redirect_valid <= 1'b1;
            end
            REDIRECT: begin
               state          <= IDLE;
               flush          <= 1'b0;
               redirect_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: exception, syscall in delay slot, interrupt priority, ERET, reset abort, back-to-back.
module tb_cp0_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        commit_valid, commit_in_ds, exc_valid, eret_valid;
   logic [31:0] commit_pc, exc_badvaddr, status_in, cause_in, epc_in;
   logic [4:0]  exc_code;
   logic [5:0]  hw_int;
   logic [31:0] cp0_we, cp0_epc, cp0_badvaddr, redirect_pc;
   logic        cp0_exl, cp0_bd, stall, flush, redirect_valid;
   logic [4:0]  cp0_exc_code;

   int errors = 0;
   int checks = 0;

   cp0_exc_ctrl #(.WIDTH(32), .EXC_VECTOR(32'hBFC00380)) dut (
      .clk(clk), .rst(rst),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_in_ds(commit_in_ds),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_badvaddr(exc_badvaddr),
      .eret_valid(eret_valid), .status_in(status_in), .cause_in(cause_in), .epc_in(epc_in),
      .hw_int(hw_int),
      .cp0_we(cp0_we), .cp0_epc(cp0_epc), .cp0_badvaddr(cp0_badvaddr), .cp0_exl(cp0_exl),
      .cp0_bd(cp0_bd), .cp0_exc_code(cp0_exc_code), .stall(stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      commit_valid = 0; commit_in_ds = 0; exc_valid = 0; eret_valid = 0;
      commit_pc = 0; exc_badvaddr = 0; status_in = 0; cause_in = 0; epc_in = 0;
      exc_code = 0; hw_int = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      cyc(); cyc();
      checks++; if (cp0_we !== 32'h0) begin errors++; $display("FAIL reset_we: got %h want %h", cp0_we, 32'h0); end
      checks++; if ({stall, flush, redirect_valid, cp0_exl, cp0_bd} !== 5'b0) begin errors++; $display("FAIL reset_ctl: got %b want 00000", {stall, flush, redirect_valid, cp0_exl, cp0_bd}); end
      checks++; if ({cp0_epc, cp0_badvaddr, redirect_pc} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {cp0_epc, cp0_badvaddr, redirect_pc}); end
      rst = 0;
      cyc();
   endtask

   task automatic test_adel();
      commit_valid = 1; commit_pc = 32'h8000_0100; exc_valid = 1; exc_code = 5'd4;
      exc_badvaddr = 32'h8000_0103;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL adel_stall_n: got %b want 1", stall); end
      cyc();
      clear_inputs();
      checks++; if (cp0_we !== 32'h0000_7100) begin errors++; $display("FAIL adel_we: got %h want %h", cp0_we, 32'h0000_7100); end
      checks++; if (cp0_epc !== 32'h8000_0100) begin errors++; $display("FAIL adel_epc: got %h want %h", cp0_epc, 32'h8000_0100); end
      checks++; if (cp0_badvaddr !== 32'h8000_0103) begin errors++; $display("FAIL adel_badv: got %h want %h", cp0_badvaddr, 32'h8000_0103); end
      checks++; if ({cp0_exc_code, cp0_exl, cp0_bd} !== {5'd4, 1'b1, 1'b0}) begin errors++; $display("FAIL adel_code: got %b want %b", {cp0_exc_code, cp0_exl, cp0_bd}, {5'd4, 1'b1, 1'b0}); end
      cyc();
      checks++; if ({flush, redirect_valid, stall} !== 3'b111) begin errors++; $display("FAIL adel_flush: got %b want 111", {flush, redirect_valid, stall}); end
      checks++; if (redirect_pc !== 32'hBFC0_0380) begin errors++; $display("FAIL adel_rpc: got %h want %h", redirect_pc, 32'hBFC0_0380); end
      checks++; if (cp0_we !== 32'h0) begin errors++; $display("FAIL adel_we_off: got %h want 0", cp0_we); end
      cyc();
      checks++; if ({flush, redirect_valid, stall} !== 3'b000) begin errors++; $display("FAIL adel_idle: got %b want 000", {flush, redirect_valid, stall}); end
   endtask

   task automatic test_syscall_ds();
      commit_valid = 1; commit_pc = 32'h8000_0204; commit_in_ds = 1; exc_valid = 1; exc_code = 5'd8;
      exc_badvaddr = 32'h1234_5678;
      cyc();
      clear_inputs();
      checks++; if (cp0_we !== 32'h0000_7000) begin errors++; $display("FAIL sys_we: got %h want %h", cp0_we, 32'h0000_7000); end
      checks++; if (cp0_epc !== 32'h8000_0200) begin errors++; $display("FAIL sys_epc: got %h want %h", cp0_epc, 32'h8000_0200); end
      checks++; if ({cp0_exc_code, cp0_bd} !== {5'd8, 1'b1}) begin errors++; $display("FAIL sys_code_bd: got %b want %b", {cp0_exc_code, cp0_bd}, {5'd8, 1'b1}); end
      cyc(); cyc();
   endtask

   task automatic test_int_priority();
      commit_valid = 1; commit_pc = 32'h8000_0400; status_in = 32'h0000_0401; hw_int = 6'd1;
      exc_valid = 1; exc_code = 5'd10; eret_valid = 1;
      cyc();
      checks++; if ({cp0_we, cp0_exc_code, cp0_exl} !== {32'h0000_7000, 5'd0, 1'b1}) begin errors++; $display("FAIL int_win: got %h/%0d/%b want 7000/0/1", cp0_we, cp0_exc_code, cp0_exl); end
      clear_inputs();
      cyc(); cyc();
      commit_valid = 1; commit_pc = 32'h8000_0400; status_in = 32'h0000_0403; hw_int = 6'd1;
      exc_valid = 1; exc_code = 5'd10;
      cyc();
      clear_inputs();
      checks++; if ({cp0_we, cp0_exc_code} !== {32'h0000_7000, 5'd10}) begin errors++; $display("FAIL int_exl_masked: got %h/%0d want 7000/10", cp0_we, cp0_exc_code); end
      checks++; if (cp0_epc !== 32'h8000_0400) begin errors++; $display("FAIL int_exl_epc: got %h want %h", cp0_epc, 32'h8000_0400); end
      cyc(); cyc();
   endtask

   task automatic test_eret();
      commit_valid = 1; commit_pc = 32'h8000_0500; eret_valid = 1; epc_in = 32'h8000_0300;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL eret_stall_n: got %b want 1", stall); end
      cyc();
      commit_valid = 0; eret_valid = 0;
      checks++; if ({cp0_we, cp0_exl, stall} !== {32'h0000_1000, 1'b0, 1'b1}) begin errors++; $display("FAIL eret_write: got %h/%b/%b want 1000/0/1", cp0_we, cp0_exl, stall); end
      cyc();
      checks++; if ({redirect_pc, flush, redirect_valid, stall} !== {32'h8000_0300, 3'b111}) begin errors++; $display("FAIL eret_redirect: got %h/%b%b%b want 80000300/111", redirect_pc, flush, redirect_valid, stall); end
      cyc();
      clear_inputs();
      checks++; if ({stall, flush} !== 2'b00) begin errors++; $display("FAIL eret_done: got %b want 00", {stall, flush}); end
   endtask

   task automatic test_commit_invalid();
      commit_valid = 0; exc_valid = 1; exc_code = 5'd4; eret_valid = 1;
      status_in = 32'h0000_0401; hw_int = 6'd1;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nocommit_stall: got %b want 0", stall); end
      cyc();
      checks++; if (cp0_we !== 32'h0) begin errors++; $display("FAIL nocommit_we: got %h want 0", cp0_we); end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      commit_valid = 1; commit_pc = 32'h8000_0600; exc_valid = 1; exc_code = 5'd5; exc_badvaddr = 32'h8000_0601;
      cyc();
      clear_inputs();
      rst = 1;
      cyc();
      rst = 0;
      checks++; if ({cp0_we, stall, flush, redirect_valid} !== 35'h0) begin errors++; $display("FAIL rstmid_zero: got %h/%b%b%b want 0", cp0_we, stall, flush, redirect_valid); end
      cyc();
      checks++; if ({flush, redirect_valid, redirect_pc} !== 34'h0) begin errors++; $display("FAIL rstmid_noredir: got %b%b/%h want 0", flush, redirect_valid, redirect_pc); end
      commit_valid = 1; commit_pc = 32'h8000_0700; exc_valid = 1; exc_code = 5'd5; exc_badvaddr = 32'h8000_0701;
      cyc();
      clear_inputs();
      checks++; if ({cp0_we, cp0_badvaddr} !== {32'h0000_7100, 32'h8000_0701}) begin errors++; $display("FAIL rstmid_after: got %h/%h want 7100/80000701", cp0_we, cp0_badvaddr); end
      cyc(); cyc();
   endtask

   task automatic test_back_to_back();
      commit_valid = 1; commit_pc = 32'h0; commit_in_ds = 1; exc_valid = 1; exc_code = 5'd12;
      cyc();
      checks++; if ({cp0_we, cp0_epc} !== {32'h0000_7000, 32'hFFFF_FFFC}) begin errors++; $display("FAIL b2b_first: got %h/%h want 7000/fffffffc", cp0_we, cp0_epc); end
      cyc();
      checks++; if ({cp0_we, flush} !== {32'h0, 1'b1}) begin errors++; $display("FAIL b2b_n2: got %h/%b want 0/1", cp0_we, flush); end
      cyc();
      checks++; if ({cp0_we, stall, flush} !== {32'h0, 1'b1, 1'b0}) begin errors++; $display("FAIL b2b_n3: got %h/%b/%b want 0/1/0", cp0_we, stall, flush); end
      cyc();
      clear_inputs();
      checks++; if ({cp0_we, cp0_exc_code} !== {32'h0000_7000, 5'd12}) begin errors++; $display("FAIL b2b_second: got %h/%0d want 7000/12", cp0_we, cp0_exc_code); end
      cyc(); cyc();
   endtask

   initial begin
      test_reset();
      test_adel();
      test_syscall_ds();
      test_int_priority();
      test_eret();
      test_commit_invalid();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
